// File: rtl/zrle_bit_packer.sv
// Packs variable-length MSB-aligned ZRL codewords into 64-bit output words.
// Optional per-packet payload bit counter: define ZRLE_PACKER_BITCNT_EN.
module zrle_bit_packer #(
  parameter int IN_W   = 68,
  parameter int SIZE_W = 7,
  parameter int OUT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   data_i,
  input  logic [SIZE_W-1:0] size_i,
  input  logic              valid_i,
  input  logic              sop_i,
  input  logic              eop_i,
  output logic              ready_o,
  output logic [OUT_W-1:0]  data_o,
  output logic [SIZE_W-1:0] bits_o,
  output logic              sop_o,
  output logic              eop_o,
  output logic              valid_o,
`ifdef ZRLE_PACKER_BITCNT_EN
  output logic [15:0]       pkt_bits_o,
`endif
  input  logic              ready_i
);

  localparam int ACC_W = 2 * IN_W;

  typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;

  state_t            state, state_next;
  logic [ACC_W-1:0]  acc, acc_next, acc_m, ins;
  logic [7:0]        fill, fill_next, fill_m;
  logic [IN_W-1:0]   data_mask;
  logic              first_pend, first_pend_next;
  logic              accept, take, eop_take, out_load, emit, final_word;
  logic [OUT_W-1:0]  word_data;
  logic [SIZE_W-1:0] word_bits;
  logic              word_sop;

  // State register, accumulator and output word register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      fill       <= '0;
      first_pend <= 1'b0;
      valid_o    <= 1'b0;
      data_o     <= '0;
      bits_o     <= '0;
      sop_o      <= 1'b0;
      eop_o      <= 1'b0;
    end else begin
      state      <= state_next;
      acc        <= acc_next;
      fill       <= fill_next;
      first_pend <= first_pend_next;
      if (out_load) begin
        valid_o <= emit;
        if (emit) begin
          data_o <= word_data;
          bits_o <= word_bits;
          sop_o  <= word_sop;
          eop_o  <= final_word;
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && sop_i) state_next = eop_i ? FLUSH : PACK;
      PACK:    if (accept && eop_i) state_next = FLUSH;
      FLUSH:   if (emit && final_word) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready_o = (state != FLUSH) && (fill <= 8'd68);
  end

  // Datapath: merge the incoming beat, then decide whether a word leaves
  always_comb begin
    accept    = valid_i && ready_o;
    take      = accept && ((state == PACK) || (state == IDLE && sop_i));
    eop_take  = take && eop_i;
    out_load  = !valid_o || ready_i;
    data_mask = data_i & ~({IN_W{1'b1}} >> size_i);
    ins       = {data_mask, {IN_W{1'b0}}} >> fill;
    acc_m     = take ? (acc | ins) : acc;
    fill_m    = fill + (take ? {1'b0, size_i} : 8'd0);

    emit       = 1'b0;
    final_word = 1'b0;
    // A word completed by an eop beat stays put so FLUSH can tag it as last
    if (state == FLUSH) begin
      emit       = out_load;
      final_word = out_load && (fill <= 8'd64);
    end else if (out_load && ((fill_m > 8'd64) || (fill_m == 8'd64 && !eop_take))) begin
      emit = 1'b1;
    end

    word_data = acc_m[ACC_W-1 -: OUT_W];
    word_bits = final_word ? fill[SIZE_W-1:0] : 7'd64;
    word_sop  = (state == IDLE) ? 1'b1 : first_pend;

    if (final_word) begin
      acc_next  = '0;
      fill_next = '0;
    end else if (emit) begin
      acc_next  = acc_m << OUT_W;
      fill_next = fill_m - 8'd64;
    end else begin
      acc_next  = acc_m;
      fill_next = fill_m;
    end

    if (emit)                          first_pend_next = 1'b0;
    else if (state == IDLE && take)    first_pend_next = 1'b1;
    else                               first_pend_next = first_pend;
  end

`ifdef ZRLE_PACKER_BITCNT_EN
  logic [15:0] pkt_cnt, pkt_cnt_m;
  logic [16:0] pkt_sum;

  // Saturating payload counter, published only on the eop word
  always_comb begin
    pkt_sum   = {1'b0, pkt_cnt} + {10'd0, size_i};
    pkt_cnt_m = pkt_cnt;
    if (state == IDLE && take)      pkt_cnt_m = {9'd0, size_i};
    else if (state == PACK && take) pkt_cnt_m = pkt_sum[16] ? 16'hFFFF : pkt_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt    <= '0;
      pkt_bits_o <= '0;
    end else begin
      pkt_cnt <= final_word ? 16'd0 : pkt_cnt_m;
      if (out_load && emit) pkt_bits_o <= final_word ? pkt_cnt_m : 16'd0;
    end
  end
`endif

endmodule

// File: tb/tb_zrle_bit_packer.sv
// Scoreboard bench for zrle_bit_packer: directed packets, expected words queued up front.
module tb_zrle_bit_packer;

  logic        clk, rst;
  logic [67:0] data_i;
  logic [6:0]  size_i;
  logic        valid_i, sop_i, eop_i, ready_o;
  logic [63:0] data_o;
  logic [6:0]  bits_o;
  logic        sop_o, eop_o, valid_o, ready_i;
`ifdef ZRLE_PACKER_BITCNT_EN
  logic [15:0] pkt_bits_o;
`endif

  typedef struct {
    logic [63:0] data;
    logic [6:0]  bits;
    logic        sop;
    logic        eop;
    logic [15:0] pkt;
  } word_t;

  word_t expQ[$];
  int assertCount = 0;
  int failCount   = 0;
  logic        holdV = 1'b0;
  logic [63:0] holdD = '0;

  zrle_bit_packer dut (
    .clk(clk), .rst(rst), .data_i(data_i), .size_i(size_i), .valid_i(valid_i),
    .sop_i(sop_i), .eop_i(eop_i), .ready_o(ready_o), .data_o(data_o),
    .bits_o(bits_o), .sop_o(sop_o), .eop_o(eop_o), .valid_o(valid_o),
`ifdef ZRLE_PACKER_BITCNT_EN
    .pkt_bits_o(pkt_bits_o),
`endif
    .ready_i(ready_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushWord(input logic [63:0] d, input int b, input logic s, input logic e, input int pkt);
    word_t w;
    w.data = d;
    w.bits = 7'(b);
    w.sop  = s;
    w.eop  = e;
    w.pkt  = 16'(pkt);
    expQ.push_back(w);
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted
  task automatic applyStimulus(input logic [67:0] d, input int sz, input logic s, input logic e);
    int t;
    data_i  = d;
    size_i  = 7'(sz);
    sop_i   = s;
    eop_i   = e;
    valid_i = 1'b1;
    t = 0;
    @(negedge clk);
    while (!ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready_o) checkOutput("accept_timeout", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    sop_i   = 1'b0;
    eop_i   = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int t;
    t = 0;
    while (expQ.size() > 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    checkOutput(name, 64'(expQ.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one transfer per negedge with valid_o & ready_i; also checks hold stability
  always @(negedge clk) begin
    word_t e;
    if (rst) begin
      holdV = 1'b0;
    end else begin
      if (valid_o && ready_i) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_word", data_o, 64'd0);
          if (data_o === 64'd0) begin
            failCount++;
            $display("[TB] FAIL unexpected_word: got a word expected none");
          end
        end else begin
          e = expQ.pop_front();
          checkOutput("data", data_o, e.data);
          checkOutput("bits", 64'(bits_o), 64'(e.bits));
          checkOutput("sop", 64'(sop_o), 64'(e.sop));
          checkOutput("eop", 64'(eop_o), 64'(e.eop));
`ifdef ZRLE_PACKER_BITCNT_EN
          checkOutput("pkt_bits", 64'(pkt_bits_o), 64'(e.pkt));
`endif
        end
      end
      if (valid_o && !ready_i) begin
        if (holdV) checkOutput("hold_data", data_o, holdD);
        holdV = 1'b1;
        holdD = data_o;
      end else begin
        holdV = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1; ready_i = 1'b1; valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    data_i = '0; size_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid", 64'(valid_o), 64'd0);
    checkOutput("rst_ready", 64'(ready_o), 64'd1);
    checkOutput("rst_data", data_o, 64'd0);
    checkOutput("rst_bits", 64'(bits_o), 64'd0);
    checkOutput("rst_sop", 64'(sop_o), 64'd0);
    checkOutput("rst_eop", 64'(eop_o), 64'd0);
    @(posedge clk); #1;

    $display("[TB] single beat packet");
    pushWord(64'h4000_0000_0000_0000, 8, 1, 1, 8);
    applyStimulus(68'h4_0000_0000_0000_0000, 8, 1, 1);
    waitDrain("drain_single");

    $display("[TB] four beats of 66 ones");
    for (int i = 0; i < 4; i++) pushWord(64'hFFFF_FFFF_FFFF_FFFF, 64, i == 0, 0, 0);
    pushWord(64'hFF00_0000_0000_0000, 8, 0, 1, 264);
    for (int i = 0; i < 4; i++) applyStimulus({68{1'b1}}, 66, i == 0, i == 3);
    waitDrain("drain_ones");

    $display("[TB] exact 64-bit packet");
    pushWord(64'hAB12_3456_789A_BCDE, 64, 1, 1, 64);
    applyStimulus({8'hAB, 60'hFFF_FFFF_FFFF_FFFF}, 8, 1, 0);
    applyStimulus({56'h12_3456_789A_BCDE, 12'hFFF}, 56, 0, 1);
    waitDrain("drain_exact");

    $display("[TB] backpressure stream");
    pushWord(64'hFFFF_FFFF_FFFF_FFFF, 64, 1, 0, 0);
    pushWord(64'hC000_0000_0000_0000, 64, 0, 0, 0);
    pushWord(64'h0FFF_FFFF_FFFF_FFFF, 64, 0, 0, 0);
    pushWord(64'hFC00_0000_0000_0000, 64, 0, 0, 0);
    pushWord(64'h0000_0000_0000_0000, 8, 0, 1, 264);
    ready_i = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          applyStimulus((i % 2 == 0) ? {68{1'b1}} : {66'd0, 2'b11}, 66, i == 0, i == 3);
      end
      begin
        repeat (10) @(negedge clk);
        checkOutput("stall_ready", 64'(ready_o), 64'd0);
        checkOutput("stall_valid", 64'(valid_o), 64'd1);
        @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    waitDrain("drain_stall");

    $display("[TB] stray beat and size-0 beats");
    data_i = {68{1'b1}}; size_i = 7'd16; sop_i = 1'b0; eop_i = 1'b0; valid_i = 1'b1;
    @(negedge clk);
    checkOutput("stray_ready", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1 valid_i = 1'b0;
    pushWord(64'hDEAD_BEEF_0000_0000, 32, 1, 1, 32);
    applyStimulus({16'hDEAD, 52'hF_FFFF_FFFF_FFFF}, 16, 1, 0);
    applyStimulus({68{1'b1}}, 0, 1, 0);
    applyStimulus({16'hBEEF, 52'hA_AAAA_AAAA_AAAA}, 16, 0, 0);
    applyStimulus({68{1'b1}}, 0, 0, 1);
    waitDrain("drain_zero_beats");

    $display("[TB] empty packet");
    pushWord(64'd0, 0, 1, 1, 0);
    applyStimulus({68{1'b1}}, 0, 1, 1);
    waitDrain("drain_empty");

    $display("[TB] reset during flush");
    ready_i = 1'b0;
    applyStimulus({68{1'b1}}, 68, 1, 1);
    repeat (2) @(negedge clk);
    checkOutput("flush_ready", 64'(ready_o), 64'd0);
    checkOutput("flush_valid", 64'(valid_o), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_valid", 64'(valid_o), 64'd0);
    checkOutput("post_rst_ready", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1 ready_i = 1'b1;
    pushWord(64'hA000_0000_0000_0000, 4, 1, 1, 4);
    applyStimulus({4'hA, 64'hFFFF_FFFF_FFFF_FFFF}, 4, 1, 1);
    waitDrain("drain_after_rst");

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
